filter_sample_tx: RTL
=====================

Name: filter_sample_tx

Overview:
Transmit end of the filter sample input interface. Accepts parallel sample words from an upstream producer via valid/ready and buffers them in a small FIFO. Serialises each word LSB-first into 2-bit symbols on data_out_o, each qualified by a one-cycle data_out_req_o strobe at a programmable rate. Sits directly upstream of the filter and drives its data_in_req_i and data_in_i ports.

Parameters:
WordWidth, 8, upstream word width; even, >= 2; symbols per word SymPerWord = WordWidth/2.
FifoDepth, 4, word FIFO depth; power of 2, >= 2.
DivWidth, 8, width of rate divider.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  reset, asynchronous, active-high.
enable_i  input  1  streaming enable.
rate_div_i  input  DivWidth  symbol period minus 1, in cycles.
word_valid_i  input  1  upstream word valid.
word_ready_o  output  1  FIFO can accept a word.
word_i  input  WordWidth  upstream word.
data_out_req_o  output  1  symbol strobe, to filter data_in_req_i.
data_out_o  output  2  symbol, to filter data_in_i.
busy_o  output  1  FIFO or shifter holds data.
underrun_o  output  1  one-cycle pulse: tick with no symbol available while streaming.

Behaviour:
- Reset (async assert, sync release): FIFO empty, shifter empty, tick counter 0, streaming flag 0. data_out_req_o=0, data_out_o=2'b00, busy_o=0, underrun_o=0. word_ready_o=1 once FIFO is empty (combinational !full).
- FIFO: push when word_valid_i && word_ready_o. word_ready_o = !full. A push and pop in the same cycle are both allowed; count is unchanged.
- Shifter (FSM EMPTY/SHIFT) holds the word plus a symbol counter (0..SymPerWord-1).
  - EMPTY -> SHIFT: when FIFO is non-empty, pop and load in the same cycle. Independent of tick.
  - In SHIFT, on a tick: emit word[1:0], shift right by 2, increment the counter.
  - After the last symbol: reload from the FIFO in the same cycle if it is non-empty (no bubble), else go to EMPTY.
- Tick generator:
  - enable_i=0: counter held at 0, no ticks, no emission. FIFO still accepts pushes; the shifter still loads.
  - enable_i=1: counter increments each cycle. Tick when counter >= rate_div_i, then counter clears to 0. rate_div_i=0 gives a tick every cycle.
  - The >= compare makes a rate_div_i decrease take effect immediately.
- Output registers:
  - data_out_req_o is registered: high exactly in the cycle after a tick that emits.
  - data_out_o is updated only with req; it holds its last value otherwise.
- Latency: word accepted in cycle t -> loaded into the shifter at end of t+1 -> first req in the cycle after the first tick at or after t+2. With rate_div_i=0 and enable_i high, first req is at t+3.
- Streaming flag:
  - Sets on the first emitted symbol while enable_i=1; clears when enable_i=0.
  - underrun_o is registered and pulses in the cycle after a tick on which streaming=1 and the shifter is EMPTY.
- busy_o = FIFO non-empty || shifter in SHIFT (registered-state derived, no combinational path from word_valid_i).
- enable_i falling mid-word: remaining symbols are kept. Emission resumes at the next tick after re-enable with no symbol lost or repeated.
- Full FIFO with word_valid_i held: no push, word_ready_o=0 until a pop.
- Reset mid-word: all buffered data discarded; the next symbol after reset comes from the first post-reset word.

Test Plan:
- rate_div_i=0, enable_i=1, push 8'hB4 -> req on 4 consecutive cycles starting t+3; data_out_o = 00,01,11,10; busy_o low the cycle after the last req.
- rate_div_i=3, push 8'hFF then 8'h00 back-to-back -> req every 4 cycles, 8 reqs total: four 11 then four 00, no gap at the word boundary, underrun_o stays 0.
- enable_i=0, push 5 words with FifoDepth=4 -> word_ready_o=0 after the 5th attempt; 4 words in FIFO plus 1 in shifter. Enable -> 20 symbols in order, none lost.
- rate_div_i=0, push one word, keep enabled -> underrun_o single-cycle pulse after the 4th req's following tick; repeats each tick until enable_i=0.
- Drop enable_i after the 2nd symbol of 8'hB4, wait 10 cycles, re-enable -> remaining symbols 11,10 emitted; total reqs = 4.
- Assert rst_i asynchronously mid-word (between edges) -> data_out_req_o, busy_o, underrun_o go 0 immediately; word_ready_o=1 after release; no stale symbols emitted.

Source files
------------

// File: rtl/filter_sample_tx.sv
// ---------------------------------------------------------------------------
// filter_sample_tx
//
// Transmit end of the filter sample input interface. Parallel sample words
// arrive from an upstream producer over a valid/ready handshake and are held
// in a small word FIFO. A shifter takes one word at a time and sends it out
// LSB-first as 2-bit symbols. Each symbol is qualified by a one-cycle
// strobe, issued at a programmable rate.
//
// Parameters:
//   WordWidth  - upstream word width (even, >= 2); WordWidth/2 symbols/word
//   FifoDepth  - word FIFO depth (power of 2, >= 2)
//   DivWidth   - width of the symbol rate divider
//
// Ports:
//   clk_i          - clock, rising edge
//   rst_i          - asynchronous active-high reset
//   enable_i       - streaming enable; when low no symbols are emitted
//   rate_div_i     - symbol period minus one, in clock cycles
//   word_valid_i   - upstream word valid
//   word_ready_o   - FIFO can accept a word (combinational !full)
//   word_i         - upstream word
//   data_out_req_o - registered symbol strobe (filter data_in_req_i)
//   data_out_o     - registered symbol (filter data_in_i), held between strobes
//   busy_o         - FIFO or shifter still holds data
//   underrun_o     - one-cycle pulse: tick while streaming with no symbol ready
// ---------------------------------------------------------------------------
module filter_sample_tx #(
    parameter int WordWidth = 8,
    parameter int FifoDepth = 4,
    parameter int DivWidth  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [DivWidth-1:0]  rate_div_i,
    input  logic                 word_valid_i,
    output logic                 word_ready_o,
    input  logic [WordWidth-1:0] word_i,
    output logic                 data_out_req_o,
    output logic [1:0]           data_out_o,
    output logic                 busy_o,
    output logic                 underrun_o
);

    localparam int SymPerWord = WordWidth / 2;
    localparam int SymCntW    = (SymPerWord > 1) ? $clog2(SymPerWord) : 1;
    localparam int AddrW      = $clog2(FifoDepth);
    localparam int CntW       = AddrW + 1;

    typedef enum logic {
        ST_EMPTY,
        ST_SHIFT
    } state_e;

    // Word FIFO storage and pointers
    logic [WordWidth-1:0] fifo_mem_q [FifoDepth];
    logic [AddrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q,  count_d;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;

    // Tick generator
    logic [DivWidth-1:0]  tick_cnt_q, tick_cnt_d;
    logic                 tick;

    // Shifter
    state_e               state_q, state_d;
    logic [WordWidth-1:0] shreg_q, shreg_d;
    logic [SymCntW-1:0]   sym_cnt_q, sym_cnt_d;
    logic                 last_sym;
    logic                 emit;

    // Output and status registers
    logic                 req_q, req_d;
    logic [1:0]           data_q, data_d;
    logic                 underrun_q, underrun_d;
    logic                 streaming_q, streaming_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(FifoDepth));
    assign push       = word_valid_i && !fifo_full;
    assign last_sym   = (sym_cnt_q == SymCntW'(SymPerWord - 1));

    // Tick generator. The >= compare lets a lowered rate_div_i take effect
    // at once instead of waiting for the counter to wrap.
    always_comb begin
        tick       = 1'b0;
        tick_cnt_d = '0;
        if (enable_i) begin
            if (tick_cnt_q >= rate_div_i) begin
                tick = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + DivWidth'(1);
            end
        end
    end

    // Shifter next state. Loading from the FIFO does not wait for a tick.
    // After the last symbol of a word the next word is loaded in the same
    // cycle, so consecutive words are sent with no gap between them.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        sym_cnt_d = sym_cnt_q;
        pop       = 1'b0;
        emit      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shreg_d   = fifo_mem_q[rd_ptr_q];
                    sym_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    emit = 1'b1;
                    if (last_sym) begin
                        if (!fifo_empty) begin
                            pop       = 1'b1;
                            shreg_d   = fifo_mem_q[rd_ptr_q];
                            sym_cnt_d = '0;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end else begin
                        shreg_d   = shreg_q >> 2;
                        sym_cnt_d = sym_cnt_q + SymCntW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leave the
    // count unchanged.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Output strobe, symbol and underrun. The streaming flag remembers that
    // at least one symbol went out during the current enable period, so an
    // idle link that was never started does not report underruns.
    always_comb begin
        req_d       = emit;
        data_d      = emit ? shreg_q[1:0] : data_q;
        underrun_d  = tick && streaming_q && (state_q == ST_EMPTY);
        streaming_d = streaming_q;
        if (!enable_i) begin
            streaming_d = 1'b0;
        end else if (emit) begin
            streaming_d = 1'b1;
        end
    end

    // FIFO storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= word_i;
        end
    end

    // All control state, with asynchronous reset discarding buffered data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tick_cnt_q  <= '0;
            state_q     <= ST_EMPTY;
            shreg_q     <= '0;
            sym_cnt_q   <= '0;
            req_q       <= 1'b0;
            data_q      <= 2'b00;
            underrun_q  <= 1'b0;
            streaming_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tick_cnt_q  <= tick_cnt_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            sym_cnt_q   <= sym_cnt_d;
            req_q       <= req_d;
            data_q      <= data_d;
            underrun_q  <= underrun_d;
            streaming_q <= streaming_d;
        end
    end

    assign word_ready_o   = !fifo_full;
    assign data_out_req_o = req_q;
    assign data_out_o     = data_q;
    assign underrun_o     = underrun_q;
    assign busy_o         = !fifo_empty || (state_q == ST_SHIFT);

endmodule
